dispatch_unit: RTL and testbench

- Sits between rename and the three reservation stations (ALU, branch, LSU).
- Buffers renamed instructions in a small FIFO and allocates a ROB entry for each one.
- Steers each instruction to the RS selected by its fu code, pulsing that RS's di_en.
- Owns the physical-register ready table (preg_rtable) that the RSs read at insert time.

---
 rtl/dispatch_unit_if.sv | 42 ++++
 rtl/dispatch_unit.sv | 229 ++++++++++++++++++++++
 tb/tb_dispatch_unit.sv | 400 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dispatch_unit_if.sv
// Handshake bundle between rename, the ROB allocator and the three reservation
// stations; dispatch_unit attaches through the slave modport.
interface dispatch_unit_if #(
  parameter int PREG_W = 7,
  parameter int ROB_W  = 5
);
  logic              ren_valid;
  logic              ren_ready;
  logic [6:0]        ren_opcode;
  logic [1:0]        ren_fu;
  logic [PREG_W-1:0] ren_pd;
  logic              ren_has_rd;
  logic [PREG_W-1:0] ren_ps1;
  logic [PREG_W-1:0] ren_ps2;
  logic [31:0]       ren_imm;
  logic              rob_full;
  logic [ROB_W-1:0]  rob_index;
  logic              rob_alloc;
  logic [2:0]        rs_full;
  logic [2:0]        di_en;
  logic [6:0]        dis_opcode;
  logic [PREG_W-1:0] dis_pd;
  logic [PREG_W-1:0] dis_ps1;
  logic [PREG_W-1:0] dis_ps2;
  logic [31:0]       dis_imm;
  logic [1:0]        dis_fu;
  logic [ROB_W-1:0]  dis_rob_index;

  modport master (
    output ren_valid, ren_opcode, ren_fu, ren_pd, ren_has_rd, ren_ps1, ren_ps2,
           ren_imm, rob_full, rob_index, rs_full,
    input  ren_ready, rob_alloc, di_en, dis_opcode, dis_pd, dis_ps1, dis_ps2,
           dis_imm, dis_fu, dis_rob_index
  );

  modport slave (
    input  ren_valid, ren_opcode, ren_fu, ren_pd, ren_has_rd, ren_ps1, ren_ps2,
           ren_imm, rob_full, rob_index, rs_full,
    output ren_ready, rob_alloc, di_en, dis_opcode, dis_pd, dis_ps1, dis_ps2,
           dis_imm, dis_fu, dis_rob_index
  );
endinterface

// File: rtl/dispatch_unit.sv
// Dispatch stage: FIFO of renamed instructions, ROB allocation, RS steering and
// the physical-register ready table. Define DISPATCH_STATS_EN for stall/dispatch counters.
module dispatch_unit #(
  parameter int NUM_PREG  = 128,
  parameter int PREG_W    = 7,
  parameter int ROB_W     = 5,
  parameter int BUF_DEPTH = 4
) (
  input  logic                clk,
  input  logic                reset,
  dispatch_unit_if.slave      bus,
  input  logic                wb_valid,
  input  logic [PREG_W-1:0]   wb_pd,
  input  logic                mispredict,
  output logic [NUM_PREG-1:0] preg_rtable
`ifdef DISPATCH_STATS_EN
  ,
  output logic [31:0]         stat_rob_stall,
  output logic [31:0]         stat_rs_stall,
  output logic [31:0]         stat_dispatched
`endif
);

  localparam int PTR_W = $clog2(BUF_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [6:0]        opcode;
    logic [1:0]        fu;
    logic              has_rd;
    logic [PREG_W-1:0] pd;
    logic [PREG_W-1:0] ps1;
    logic [PREG_W-1:0] ps2;
    logic [31:0]       imm;
  } entry_t;

  entry_t                mem_q [BUF_DEPTH];
  entry_t                mem_d [BUF_DEPTH];
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [NUM_PREG-1:0]   rtable_q, rtable_d;
  logic                  illegal_seen_q, illegal_seen_d;

  entry_t                head_s;
  entry_t                new_s;
  logic                  nonempty_s;
  logic                  head_illegal_s;
  logic                  rs_blk_s;
  logic                  fire_s;
  logic                  discard_s;
  logic                  push_s;
  logic                  pop_s;
  logic                  ren_ready_s;
  logic [2:0]            di_en_s;
  logic                  clr_s;
  logic                  set_s;
  logic [ROB_W-1:0]      rob_idx_s;

  assign new_s = '{opcode: bus.ren_opcode, fu: bus.ren_fu, has_rd: bus.ren_has_rd,
                   pd: bus.ren_pd, ps1: bus.ren_ps1, ps2: bus.ren_ps2, imm: bus.ren_imm};

  // Head decode and the fire / discard / push decisions
  always_comb begin
    head_s         = mem_q[rd_ptr_q];
    nonempty_s     = (count_q != {CNT_W{1'b0}});
    head_illegal_s = (head_s.fu == 2'd3);
    case (head_s.fu)
      2'd0:    rs_blk_s = bus.rs_full[0];
      2'd1:    rs_blk_s = bus.rs_full[1];
      2'd2:    rs_blk_s = bus.rs_full[2];
      default: rs_blk_s = 1'b0;
    endcase
    fire_s      = nonempty_s && !bus.rob_full && !rs_blk_s && !head_illegal_s && !mispredict;
    discard_s   = nonempty_s && head_illegal_s && !mispredict;
    ren_ready_s = (count_q != CNT_W'(BUF_DEPTH)) && !mispredict;
    push_s      = bus.ren_valid && ren_ready_s;
    pop_s       = fire_s || discard_s;
  end

  // One-hot insert strobe toward the selected reservation station
  always_comb begin
    di_en_s = 3'b000;
    if (fire_s) begin
      case (head_s.fu)
        2'd0:    di_en_s = 3'b001;
        2'd1:    di_en_s = 3'b010;
        2'd2:    di_en_s = 3'b100;
        default: di_en_s = 3'b000;
      endcase
    end else begin
      di_en_s = 3'b000;
    end
  end

  // FIFO pointer, count and storage update; a flush empties the queue
  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (mispredict) begin
      rd_ptr_d = {PTR_W{1'b0}};
      wr_ptr_d = {PTR_W{1'b0}};
      count_d  = {CNT_W{1'b0}};
    end else begin
      if (push_s) begin
        mem_d[wr_ptr_q] = new_s;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1'b1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1'b1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({push_s, pop_s})
        2'b10:   count_d = count_q + CNT_W'(1'b1);
        2'b01:   count_d = count_q - CNT_W'(1'b1);
        default: count_d = count_q;
      endcase
    end
  end

  assign illegal_seen_d = illegal_seen_q || discard_s;
  assign clr_s = fire_s && head_s.has_rd && (head_s.pd != {PREG_W{1'b0}});
  assign set_s = wb_valid && (wb_pd != {PREG_W{1'b0}});

  // Ready table: the clear is applied last so a newly allocated producer beats a stale writeback
  always_comb begin
    rtable_d = rtable_q;
    if (set_s) begin
      rtable_d[wb_pd] = 1'b1;
    end else begin
      rtable_d = rtable_q;
    end
    if (clr_s) begin
      rtable_d[head_s.pd] = 1'b0;
    end else begin
      rtable_d[0] = 1'b1;
    end
    rtable_d[0] = 1'b1;
  end

  // State registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < BUF_DEPTH; i++) begin
        mem_q[i] <= {$bits(entry_t){1'b0}};
      end
      rd_ptr_q       <= {PTR_W{1'b0}};
      wr_ptr_q       <= {PTR_W{1'b0}};
      count_q        <= {CNT_W{1'b0}};
      rtable_q       <= {NUM_PREG{1'b1}};
      illegal_seen_q <= 1'b0;
    end else begin
      mem_q          <= mem_d;
      rd_ptr_q       <= rd_ptr_d;
      wr_ptr_q       <= wr_ptr_d;
      count_q        <= count_d;
      rtable_q       <= rtable_d;
      illegal_seen_q <= illegal_seen_d;
    end
  end

  assign rob_idx_s         = bus.rob_index;
  assign bus.ren_ready     = ren_ready_s;
  assign bus.rob_alloc     = fire_s;
  assign bus.di_en         = di_en_s;
  assign bus.dis_opcode    = head_s.opcode;
  assign bus.dis_pd        = head_s.pd;
  assign bus.dis_ps1       = head_s.ps1;
  assign bus.dis_ps2       = head_s.ps2;
  assign bus.dis_imm       = head_s.imm;
  assign bus.dis_fu        = head_s.fu;
  assign bus.dis_rob_index = rob_idx_s;
  assign preg_rtable       = rtable_q;

`ifdef DISPATCH_STATS_EN
  logic [31:0] stat_rob_q, stat_rob_d;
  logic [31:0] stat_rs_q,  stat_rs_d;
  logic [31:0] stat_dis_q, stat_dis_d;
  logic        rob_stall_s, rs_stall_s;

  assign rob_stall_s = nonempty_s && bus.rob_full;
  assign rs_stall_s  = nonempty_s && !bus.rob_full && rs_blk_s;

  // Saturating event counters; they ignore flushes
  always_comb begin
    stat_rob_d = stat_rob_q;
    stat_rs_d  = stat_rs_q;
    stat_dis_d = stat_dis_q;
    if (rob_stall_s && (stat_rob_q != 32'hFFFF_FFFF)) begin
      stat_rob_d = stat_rob_q + 32'd1;
    end else begin
      stat_rob_d = stat_rob_q;
    end
    if (rs_stall_s && (stat_rs_q != 32'hFFFF_FFFF)) begin
      stat_rs_d = stat_rs_q + 32'd1;
    end else begin
      stat_rs_d = stat_rs_q;
    end
    if (fire_s && (stat_dis_q != 32'hFFFF_FFFF)) begin
      stat_dis_d = stat_dis_q + 32'd1;
    end else begin
      stat_dis_d = stat_dis_q;
    end
  end

  // Counter registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_rob_q <= 32'd0;
      stat_rs_q  <= 32'd0;
      stat_dis_q <= 32'd0;
    end else begin
      stat_rob_q <= stat_rob_d;
      stat_rs_q  <= stat_rs_d;
      stat_dis_q <= stat_dis_d;
    end
  end

  assign stat_rob_stall  = stat_rob_q;
  assign stat_rs_stall   = stat_rs_q;
  assign stat_dispatched = stat_dis_q;
`endif

endmodule

// File: tb/tb_dispatch_unit.sv
// Self-checking bench for dispatch_unit: directed sequences, a vector table and
// randomized traffic against a queue-based reference model.
module tb_dispatch_unit;
  localparam int NUM_PREG = 128;
  localparam int PREG_W   = 7;
  localparam int ROB_W    = 5;

  logic                clk = 1'b0;
  logic                reset;
  logic                wb_valid;
  logic [PREG_W-1:0]   wb_pd;
  logic                mispredict;
  logic [NUM_PREG-1:0] preg_rtable;
`ifdef DISPATCH_STATS_EN
  logic [31:0] stat_rob_stall, stat_rs_stall, stat_dispatched;
`endif

  int checks = 0;
  int errors = 0;
  logic [NUM_PREG-1:0] exp_rt;

  dispatch_unit_if #(.PREG_W(PREG_W), .ROB_W(ROB_W)) bus ();

  dispatch_unit #(.NUM_PREG(NUM_PREG), .PREG_W(PREG_W), .ROB_W(ROB_W), .BUF_DEPTH(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .wb_valid    (wb_valid),
    .wb_pd       (wb_pd),
    .mispredict  (mispredict),
    .preg_rtable (preg_rtable)
`ifdef DISPATCH_STATS_EN
    ,
    .stat_rob_stall  (stat_rob_stall),
    .stat_rs_stall   (stat_rs_stall),
    .stat_dispatched (stat_dispatched)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] fu;
    logic       rob_full;
    logic [2:0] rs_full;
    logic       mp;
    logic [2:0] exp_di;
    logic       exp_alloc;
    logic       exp_ready;
  } vec_t;

  typedef struct {
    logic [1:0]        fu;
    logic [6:0]        opcode;
    logic [PREG_W-1:0] pd;
    logic [PREG_W-1:0] ps1;
    logic [PREG_W-1:0] ps2;
    logic              has_rd;
    logic [31:0]       imm;
  } ins_t;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic idle();
    bus.ren_valid  = 1'b0;
    bus.ren_opcode = 7'd0;
    bus.ren_fu     = 2'd0;
    bus.ren_pd     = 7'd0;
    bus.ren_has_rd = 1'b0;
    bus.ren_ps1    = 7'd0;
    bus.ren_ps2    = 7'd0;
    bus.ren_imm    = 32'd0;
    bus.rob_full   = 1'b0;
    bus.rob_index  = 5'd0;
    bus.rs_full    = 3'b000;
    wb_valid       = 1'b0;
    wb_pd          = 7'd0;
    mispredict     = 1'b0;
  endtask

  task automatic put(input logic [1:0] fu, input logic [6:0] pd, input logic has_rd);
    bus.ren_valid  = 1'b1;
    bus.ren_fu     = fu;
    bus.ren_pd     = pd;
    bus.ren_has_rd = has_rd;
    bus.ren_ps1    = pd + 7'd1;
    bus.ren_ps2    = pd + 7'd2;
    bus.ren_opcode = 7'h13;
    bus.ren_imm    = {25'd0, pd};
  endtask

  // Push one fu=0 instruction, then fire it next cycle while a writeback is broadcast
  task automatic fire_with_wb(input logic [6:0] pd, input logic [6:0] wbpd, input string name);
    put(2'd0, pd, 1'b1);
    tick();
    bus.ren_valid = 1'b0;
    wb_valid      = 1'b1;
    wb_pd         = wbpd;
    settle();
    chk({name, "_alloc"}, bus.rob_alloc, 1'b1);
    tick();
    wb_valid = 1'b0;
    settle();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t vecs[12];
    ins_t q[$];
    ins_t h, n;
    logic [NUM_PREG-1:0] mrt;
    logic m_ready, m_fire, m_disc, has, push, clr, setb;
    logic [2:0] m_di;

    vecs[0]  = '{2'd0, 1'b0, 3'b000, 1'b0, 3'b001, 1'b1, 1'b1};
    vecs[1]  = '{2'd1, 1'b0, 3'b000, 1'b0, 3'b010, 1'b1, 1'b1};
    vecs[2]  = '{2'd2, 1'b0, 3'b000, 1'b0, 3'b100, 1'b1, 1'b1};
    vecs[3]  = '{2'd0, 1'b1, 3'b000, 1'b0, 3'b000, 1'b0, 1'b1};
    vecs[4]  = '{2'd1, 1'b0, 3'b010, 1'b0, 3'b000, 1'b0, 1'b1};
    vecs[5]  = '{2'd1, 1'b0, 3'b101, 1'b0, 3'b010, 1'b1, 1'b1};
    vecs[6]  = '{2'd2, 1'b0, 3'b100, 1'b0, 3'b000, 1'b0, 1'b1};
    vecs[7]  = '{2'd2, 1'b0, 3'b011, 1'b0, 3'b100, 1'b1, 1'b1};
    vecs[8]  = '{2'd0, 1'b0, 3'b000, 1'b1, 3'b000, 1'b0, 1'b0};
    vecs[9]  = '{2'd3, 1'b0, 3'b000, 1'b0, 3'b000, 1'b0, 1'b1};
    vecs[10] = '{2'd0, 1'b0, 3'b001, 1'b0, 3'b000, 1'b0, 1'b1};
    vecs[11] = '{2'd3, 1'b1, 3'b111, 1'b1, 3'b000, 1'b0, 1'b0};

    idle();
    reset = 1'b1;
    #12;
    chk("rst_ren_ready", bus.ren_ready, 1'b1);
    chk("rst_rob_alloc", bus.rob_alloc, 1'b0);
    chk("rst_di_en", bus.di_en, 3'b000);
    chk("rst_dis_pd", bus.dis_pd, 7'd0);
    chk("rst_dis_opcode", bus.dis_opcode, 7'd0);
    chk("rst_dis_imm", bus.dis_imm, 32'd0);
    chk("rst_rtable", preg_rtable, {NUM_PREG{1'b1}});
    @(negedge clk);
    reset  = 1'b0;
    exp_rt = {NUM_PREG{1'b1}};
    tick();

    // Single instruction, one-cycle latency, no bypass
    put(2'd0, 7'd5, 1'b1);
    bus.ren_ps1 = 7'd3;
    bus.ren_ps2 = 7'd4;
    settle();
    chk("s1_ready", bus.ren_ready, 1'b1);
    chk("s1_no_bypass", bus.di_en, 3'b000);
    tick();
    bus.ren_valid = 1'b0;
    bus.rob_index = 5'd7;
    settle();
    chk("s1_di_en", bus.di_en, 3'b001);
    chk("s1_alloc", bus.rob_alloc, 1'b1);
    chk("s1_dis_pd", bus.dis_pd, 7'd5);
    chk("s1_dis_ps1", bus.dis_ps1, 7'd3);
    chk("s1_dis_ps2", bus.dis_ps2, 7'd4);
    chk("s1_rob_index", bus.dis_rob_index, 5'd7);
    chk("s1_rt5_before", preg_rtable[5], 1'b1);
    tick();
    exp_rt[5] = 1'b0;
    settle();
    chk("s1_di_en_after", bus.di_en, 3'b000);
    chk("s1_rtable", preg_rtable, exp_rt);

    // Backpressure from the branch RS fills the FIFO
    bus.rs_full = 3'b010;
    for (int i = 0; i < 4; i++) begin
      put(2'd1, 7'(20 + i), 1'b0);
      settle();
      chk("s2_blocked_di_en", bus.di_en, 3'b000);
      tick();
    end
    bus.ren_valid = 1'b0;
    settle();
    chk("s2_full_ready", bus.ren_ready, 1'b0);
    chk("s2_full_di_en", bus.di_en, 3'b000);
    tick();
    bus.rs_full = 3'b000;
    for (int i = 0; i < 4; i++) begin
      settle();
      chk("s2_drain_di_en", bus.di_en, 3'b010);
      chk("s2_drain_pd", bus.dis_pd, 7'(20 + i));
      tick();
    end
    settle();
    chk("s2_empty_di_en", bus.di_en, 3'b000);
    chk("s2_empty_ready", bus.ren_ready, 1'b1);

    // ROB stall, then fire in the release cycle
    bus.rob_full = 1'b1;
    put(2'd2, 7'd30, 1'b1);
    tick();
    bus.ren_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      settle();
      chk("s3_stall_alloc", bus.rob_alloc, 1'b0);
      chk("s3_stall_di_en", bus.di_en, 3'b000);
      tick();
    end
    bus.rob_full = 1'b0;
    settle();
    chk("s3_release_di_en", bus.di_en, 3'b100);
    chk("s3_release_alloc", bus.rob_alloc, 1'b1);
    chk("s3_release_pd", bus.dis_pd, 7'd30);
    tick();
    exp_rt[30] = 1'b0;
    settle();
    chk("s3_after_di_en", bus.di_en, 3'b000);
    chk("s3_rtable", preg_rtable, exp_rt);

    // Writeback races against the dispatch clear
    fire_with_wb(7'd9, 7'd9, "s4_same");
    exp_rt[9] = 1'b0;
    chk("s4_same_rtable", preg_rtable, exp_rt);
    fire_with_wb(7'd12, 7'd9, "s4_diff_a");
    exp_rt[12] = 1'b0;
    exp_rt[9]  = 1'b1;
    chk("s4_diff_a_rtable", preg_rtable, exp_rt);
    fire_with_wb(7'd9, 7'd12, "s4_diff_b");
    exp_rt[9]  = 1'b0;
    exp_rt[12] = 1'b1;
    chk("s4_diff_b_rtable", preg_rtable, exp_rt);

    // Flush with three queued instructions
    bus.rs_full = 3'b111;
    put(2'd0, 7'd40, 1'b1);
    tick();
    put(2'd1, 7'd41, 1'b1);
    tick();
    put(2'd2, 7'd42, 1'b1);
    tick();
    bus.ren_valid = 1'b0;
    bus.rs_full   = 3'b000;
    mispredict    = 1'b1;
    settle();
    chk("s5_flush_di_en", bus.di_en, 3'b000);
    chk("s5_flush_alloc", bus.rob_alloc, 1'b0);
    chk("s5_flush_ready", bus.ren_ready, 1'b0);
    tick();
    mispredict = 1'b0;
    settle();
    chk("s5_post_di_en", bus.di_en, 3'b000);
    chk("s5_post_ready", bus.ren_ready, 1'b1);
    chk("s5_rtable", preg_rtable, exp_rt);
    put(2'd0, 7'd43, 1'b0);
    tick();
    bus.ren_valid = 1'b0;
    settle();
    chk("s5_new_head_pd", bus.dis_pd, 7'd43);
    chk("s5_new_head_di_en", bus.di_en, 3'b001);
    tick();

    // Zero register and illegal fu
    fire_with_wb(7'd0, 7'd0, "s6_zero");
    chk("s6_rt0", preg_rtable[0], 1'b1);
    chk("s6_rtable", preg_rtable, exp_rt);
    put(2'd3, 7'd50, 1'b1);
    tick();
    bus.ren_valid = 1'b0;
    settle();
    chk("s6_illegal_alloc", bus.rob_alloc, 1'b0);
    chk("s6_illegal_di_en", bus.di_en, 3'b000);
    tick();
    put(2'd0, 7'd51, 1'b0);
    settle();
    chk("s6_discarded_di_en", bus.di_en, 3'b000);
    tick();
    bus.ren_valid = 1'b0;
    settle();
    chk("s6_next_pd", bus.dis_pd, 7'd51);
    chk("s6_next_di_en", bus.di_en, 3'b001);
    chk("s6_rtable_kept", preg_rtable, exp_rt);
    tick();

    // Vector table: one queued instruction against a single cycle of side conditions
    for (int i = 0; i < 12; i++) begin
      idle();
      put(vecs[i].fu, 7'd60, 1'b0);
      tick();
      bus.ren_valid = 1'b0;
      bus.rob_full  = vecs[i].rob_full;
      bus.rs_full   = vecs[i].rs_full;
      mispredict    = vecs[i].mp;
      settle();
      chk($sformatf("vec%0d_di_en", i), bus.di_en, vecs[i].exp_di);
      chk($sformatf("vec%0d_alloc", i), bus.rob_alloc, vecs[i].exp_alloc);
      chk($sformatf("vec%0d_ready", i), bus.ren_ready, vecs[i].exp_ready);
      tick();
      idle();
      mispredict = 1'b1;
      tick();
      mispredict = 1'b0;
    end

    // Asynchronous reset while instructions are queued
    bus.rs_full = 3'b111;
    put(2'd0, 7'd70, 1'b1);
    tick();
    put(2'd1, 7'd71, 1'b1);
    tick();
    bus.ren_valid = 1'b0;
    bus.rs_full   = 3'b000;
    reset         = 1'b1;
    settle();
    chk("rst_mid_di_en", bus.di_en, 3'b000);
    chk("rst_mid_alloc", bus.rob_alloc, 1'b0);
    chk("rst_mid_ready", bus.ren_ready, 1'b1);
    chk("rst_mid_rtable", preg_rtable, {NUM_PREG{1'b1}});
    @(negedge clk);
    reset = 1'b0;
    tick();

    // Randomized traffic against the reference model
    mrt = {NUM_PREG{1'b1}};
    for (int c = 0; c < 3000; c++) begin
      int r;
      bus.ren_valid  = ($urandom_range(0, 9) < 7);
      r              = $urandom_range(0, 19);
      bus.ren_fu     = (r == 0) ? 2'd3 : 2'(r % 3);
      bus.ren_pd     = 7'($urandom_range(0, 15));
      bus.ren_has_rd = 1'($urandom_range(0, 1));
      bus.ren_ps1    = 7'($urandom_range(0, 127));
      bus.ren_ps2    = 7'($urandom_range(0, 127));
      bus.ren_opcode = 7'($urandom_range(0, 127));
      bus.ren_imm    = $urandom;
      bus.rob_full   = ($urandom_range(0, 9) < 2);
      bus.rob_index  = 5'($urandom_range(0, 31));
      bus.rs_full    = {($urandom_range(0, 99) < 15), ($urandom_range(0, 99) < 15),
                        ($urandom_range(0, 99) < 15)};
      wb_valid       = 1'($urandom_range(0, 1));
      wb_pd          = 7'($urandom_range(0, 15));
      mispredict     = ($urandom_range(0, 99) < 4);
      settle();

      has     = (q.size() != 0);
      h       = has ? q[0] : '{2'd0, 7'd0, 7'd0, 7'd0, 7'd0, 1'b0, 32'd0};
      m_ready = (q.size() < 4) && !mispredict;
      m_fire  = has && (h.fu != 2'd3) && !bus.rob_full && !bus.rs_full[h.fu] && !mispredict;
      m_disc  = has && (h.fu == 2'd3) && !mispredict;
      m_di    = m_fire ? (3'b001 << h.fu) : 3'b000;

      chk("rnd_ready", bus.ren_ready, m_ready);
      chk("rnd_alloc", bus.rob_alloc, m_fire);
      chk("rnd_di_en", bus.di_en, m_di);
      chk("rnd_rob_index", bus.dis_rob_index, bus.rob_index);
      chk("rnd_rtable", preg_rtable, mrt);
      if (has) begin
        chk("rnd_dis_fu", bus.dis_fu, h.fu);
        chk("rnd_dis_pd", bus.dis_pd, h.pd);
        chk("rnd_dis_ps", {bus.dis_ps1, bus.dis_ps2}, {h.ps1, h.ps2});
        chk("rnd_dis_op_imm", {bus.dis_opcode, bus.dis_imm}, {h.opcode, h.imm});
      end

      push = bus.ren_valid && m_ready;
      n = '{bus.ren_fu, bus.ren_opcode, bus.ren_pd, bus.ren_ps1, bus.ren_ps2,
            bus.ren_has_rd, bus.ren_imm};
      if (mispredict) begin
        q.delete();
      end else begin
        if (m_fire || m_disc) void'(q.pop_front());
        if (push) q.push_back(n);
      end

      clr  = m_fire && h.has_rd && (h.pd != 7'd0);
      setb = wb_valid && (wb_pd != 7'd0);
      if (clr && setb && (h.pd == wb_pd)) begin
        mrt[h.pd] = 1'b0;
      end else begin
        if (setb) mrt[wb_pd] = 1'b1;
        if (clr)  mrt[h.pd]  = 1'b0;
      end
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
